// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchronised, counter-qualified button debouncer with edge pulses and press count
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in,
    output logic               level,
    output logic               rise,
    output logic               fall,
    output logic [COUNT_W-1:0] presses
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               s1_q, s2_q;
    logic               level_q, level_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic [COUNT_W-1:0] presses_q, presses_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= STABLE_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            presses_q <= '0;
        end else begin
            s1_q      <= in;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            presses_q <= presses_d;
        end
    end

    // A sample matching the current level while waiting is a glitch and wins over acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LOW: begin
                if (s2_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s2_q) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s2_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_LOW: begin
                if (s2_q) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
        level_d   = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
        presses_d = presses_q + {{(COUNT_W-1){1'b0}}, rise_d};
    end

    assign level   = level_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign presses = presses_q;

endmodule
